// File: rtl/pn_pkg.sv
// Shared definitions for the PN calculator token driver: modes, opcodes,
// error codes and the transaction state encoding.
package pn_pkg;

    localparam int PN_TOK_W      = 4;
    localparam int PN_TOKENS_MAX = 12;

    localparam logic [1:0] PN_PRE_GRP  = 2'd0;
    localparam logic [1:0] PN_POST_GRP = 2'd1;
    localparam logic [1:0] PN_PRE_STK  = 2'd2;
    localparam logic [1:0] PN_POST_STK = 2'd3;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MUL     = 3'd2;
    localparam logic [2:0] OP_ABS_SUM = 3'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_CFG     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_COUNT   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SEND,
        ST_WAIT,
        ST_COLLECT,
        ST_FIN,
        ST_GAP
    } pn_state_e;

    function automatic logic isStackMode(input logic [1:0] mode);
        return (mode == PN_PRE_STK) || (mode == PN_POST_STK);
    endfunction

    // Group modes yield one result per 3-token group; stack modes fold to one result.
    function automatic logic [2:0] expectedCount(input logic [1:0] mode, input logic [3:0] len);
        logic [3:0] groups;
        groups = len / 4'd3;
        return isStackMode(mode) ? 3'd1 : groups[2:0];
    endfunction

endpackage

// File: rtl/pn_expr_driver_if.sv
// Token/result bus between the expression driver and the PN calculator.
interface pn_expr_driver_if;

    logic [1:0]         pnMode;
    logic               pnOperator;
    logic [2:0]         pnIn;
    logic               pnInValid;
    logic               pnOutValid;
    logic signed [31:0] pnOut;

    modport master (
        output pnMode, pnOperator, pnIn, pnInValid,
        input  pnOutValid, pnOut
    );

    modport slave (
        input  pnMode, pnOperator, pnIn, pnInValid,
        output pnOutValid, pnOut
    );

endinterface

// File: rtl/pn_tok_serializer.sv
// Holds the packed token vector and emits one token per cycle, with the
// calculator mode attached to the first token only.
module pn_tok_serializer
    import pn_pkg::*;
#(
    parameter int TOKENS_MAX = PN_TOKENS_MAX
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load_i,
    input  logic [PN_TOK_W*TOKENS_MAX-1:0] tokens_i,
    input  logic                           go_i,
    input  logic [1:0]                     mode_i,
    input  logic [3:0]                     len_i,
    output logic [1:0]                     pnMode_o,
    output logic                           pnOperator_o,
    output logic [2:0]                     pnIn_o,
    output logic                           pnInValid_o,
    output logic                           last_o
);

    logic [PN_TOK_W*TOKENS_MAX-1:0] tokQ, tokD;
    logic [3:0] remQ, remD;
    logic       validQ, validD;
    logic [1:0] modeQ, modeD;
    logic       opQ, opD;
    logic [2:0] inQ, inD;

    // Token fields default to zero so the bus is quiet whenever valid is low.
    always_comb begin
        tokD   = tokQ;
        remD   = remQ;
        validD = 1'b0;
        modeD  = 2'd0;
        opD    = 1'b0;
        inD    = 3'd0;
        if (load_i) begin
            tokD = tokens_i;
        end else if (go_i) begin
            validD = 1'b1;
            modeD  = mode_i;
            opD    = tokQ[3];
            inD    = tokQ[2:0];
            remD   = len_i - 4'd1;
            tokD   = tokQ >> PN_TOK_W;
        end else if (validQ && remQ != 4'd0) begin
            validD = 1'b1;
            opD    = tokQ[3];
            inD    = tokQ[2:0];
            remD   = remQ - 4'd1;
            tokD   = tokQ >> PN_TOK_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tokQ   <= '0;
            remQ   <= 4'd0;
            validQ <= 1'b0;
            modeQ  <= 2'd0;
            opQ    <= 1'b0;
            inQ    <= 3'd0;
        end else begin
            tokQ   <= tokD;
            remQ   <= remD;
            validQ <= validD;
            modeQ  <= modeD;
            opQ    <= opD;
            inQ    <= inD;
        end
    end

    assign pnMode_o     = modeQ;
    assign pnOperator_o = opQ;
    assign pnIn_o       = inQ;
    assign pnInValid_o  = validQ;
    assign last_o       = validQ && (remQ == 4'd0);

endmodule

// File: rtl/pn_expr_driver.sv
// Streams a packed PN expression into the calculator, then collects and
// checks the result burst with timeout and count checking.
module pn_expr_driver
    import pn_pkg::*;
#(
    parameter int TOKENS_MAX = PN_TOKENS_MAX,
    parameter int TIMEOUT    = 1024,
    parameter int GAP_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [1:0]                     cfgMode_i,
    input  logic [3:0]                     cfgLen_i,
    input  logic [PN_TOK_W*TOKENS_MAX-1:0] cfgTokens_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [1:0]                     err_o,
    output logic [2:0]                     resCnt_o,
    output logic [127:0]                   resData_o,
    pn_expr_driver_if.master               pn
);

    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    pn_state_e      stateQ;
    logic [1:0]     modeQ;
    logic [3:0]     lenQ;
    logic [2:0]     expQ;
    logic [2:0]     resCntQ;
    logic [127:0]   resDataQ;
    logic [1:0]     errQ;
    logic           busyQ;
    logic           doneQ;
    logic           overrunQ;
    logic [TO_W-1:0]  toCntQ;
    logic [GAP_W-1:0] gapCntQ;

    logic cfgBad;
    logic serLoad;
    logic serGo;
    logic serLast;

    assign cfgBad  = (lenQ == 4'd0) || (int'(lenQ) > TOKENS_MAX) ||
                     (!isStackMode(modeQ) && (lenQ % 4'd3 != 4'd0));
    assign serLoad = (stateQ == ST_IDLE) && start_i;
    assign serGo   = (stateQ == ST_CHECK) && !cfgBad;

    pn_tok_serializer #(
        .TOKENS_MAX (TOKENS_MAX)
    ) u_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (serLoad),
        .tokens_i     (cfgTokens_i),
        .go_i         (serGo),
        .mode_i       (modeQ),
        .len_i        (lenQ),
        .pnMode_o     (pn.pnMode),
        .pnOperator_o (pn.pnOperator),
        .pnIn_o       (pn.pnIn),
        .pnInValid_o  (pn.pnInValid),
        .last_o       (serLast)
    );

    // done is raised on the transition into FIN, so it is high exactly while in FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= ST_IDLE;
            modeQ    <= 2'd0;
            lenQ     <= 4'd0;
            expQ     <= 3'd0;
            resCntQ  <= 3'd0;
            resDataQ <= '0;
            errQ     <= ERR_OK;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            overrunQ <= 1'b0;
            toCntQ   <= '0;
            gapCntQ  <= '0;
        end else begin
            doneQ <= 1'b0;
            case (stateQ)
                ST_IDLE: begin
                    if (start_i) begin
                        modeQ    <= cfgMode_i;
                        lenQ     <= cfgLen_i;
                        resDataQ <= '0;
                        resCntQ  <= 3'd0;
                        errQ     <= ERR_OK;
                        overrunQ <= 1'b0;
                        busyQ    <= 1'b1;
                        stateQ   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cfgBad) begin
                        errQ   <= ERR_CFG;
                        doneQ  <= 1'b1;
                        stateQ <= ST_FIN;
                    end else begin
                        expQ   <= expectedCount(modeQ, lenQ);
                        stateQ <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (serLast) begin
                        toCntQ <= '0;
                        stateQ <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pn.pnOutValid) begin
                        resDataQ[31:0] <= pn.pnOut;
                        resCntQ        <= 3'd1;
                        stateQ         <= ST_COLLECT;
                    end else if (toCntQ == TO_W'(TIMEOUT - 1)) begin
                        errQ   <= ERR_TIMEOUT;
                        doneQ  <= 1'b1;
                        stateQ <= ST_FIN;
                    end else begin
                        toCntQ <= toCntQ + 1'b1;
                    end
                end
                ST_COLLECT: begin
                    // Results past the expected count are dropped but remembered as overrun.
                    if (pn.pnOutValid) begin
                        if (resCntQ < 3'd4 && resCntQ < expQ) begin
                            for (int i = 0; i < 4; i++) begin
                                if (resCntQ == 3'(i)) resDataQ[32*i +: 32] <= pn.pnOut;
                            end
                            resCntQ <= resCntQ + 3'd1;
                        end else begin
                            overrunQ <= 1'b1;
                        end
                    end else begin
                        errQ   <= (overrunQ || resCntQ != expQ) ? ERR_COUNT : ERR_OK;
                        doneQ  <= 1'b1;
                        stateQ <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    gapCntQ <= '0;
                    stateQ  <= ST_GAP;
                end
                ST_GAP: begin
                    if (gapCntQ == GAP_W'(GAP_CYCLES - 1)) begin
                        busyQ  <= 1'b0;
                        stateQ <= ST_IDLE;
                    end else begin
                        gapCntQ <= gapCntQ + 1'b1;
                    end
                end
                default: stateQ <= ST_IDLE;
            endcase
        end
    end

    assign busy_o    = busyQ;
    assign done_o    = doneQ;
    assign err_o     = errQ;
    assign resCnt_o  = resCntQ;
    assign resData_o = resDataQ;

endmodule

// File: tb/tb_pn_expr_driver.sv
// Directed self-checking bench for pn_expr_driver with TIMEOUT shortened to 16.
module tb_pn_expr_driver;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   cfgMode;
    logic [3:0]   cfgLen;
    logic [47:0]  cfgTokens;
    logic         busy;
    logic         done;
    logic [1:0]   err;
    logic [2:0]   resCnt;
    logic [127:0] resData;

    int nCompared   = 0;
    int nMismatched = 0;
    int doneCnt     = 0;
    int validCnt    = 0;

    pn_expr_driver_if pnBus ();

    pn_expr_driver #(
        .TOKENS_MAX (12),
        .TIMEOUT    (16),
        .GAP_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .cfgMode_i   (cfgMode),
        .cfgLen_i    (cfgLen),
        .cfgTokens_i (cfgTokens),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .resCnt_o    (resCnt),
        .resData_o   (resData),
        .pn          (pnBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts done pulses and token cycles over the whole run.
    always @(posedge clk) begin
        if (done === 1'b1) doneCnt++;
        if (pnBus.pnInValid === 1'b1) validCnt++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] len, input logic [47:0] tokens);
        start     = 1'b1;
        cfgMode   = mode;
        cfgLen    = len;
        cfgTokens = tokens;
        tick();
        start = 1'b0;
    endtask

    // Waits for the token burst and records it; returns on the first idle cycle after it.
    task automatic runSend(output int nValid, output logic [47:0] seen,
                           output logic [1:0] firstMode, output int modeBad);
        int guard;
        nValid    = 0;
        seen      = '0;
        firstMode = 2'd0;
        modeBad   = 0;
        guard     = 0;
        while (pnBus.pnInValid !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        while (pnBus.pnInValid === 1'b1 && nValid < 12) begin
            if (nValid == 0) firstMode = pnBus.pnMode;
            else if (pnBus.pnMode !== 2'd0) modeBad++;
            seen[4*nValid +: 4] = {pnBus.pnOperator, pnBus.pnIn};
            nValid++;
            tick();
        end
    endtask

    task automatic runPostfixAdd();
        int n, mb, d0;
        logic [47:0] seen;
        logic [1:0]  fm;
        d0 = doneCnt;
        applyStimulus(2'd3, 4'd3, 48'h843);
        checkOutput("pf_busy_check", 128'(busy), 128'd1);
        runSend(n, seen, fm, mb);
        checkOutput("pf_valid_cycles", 128'(n), 128'd3);
        checkOutput("pf_tokens", 128'(seen), 128'h843);
        checkOutput("pf_first_mode", 128'(fm), 128'd3);
        checkOutput("pf_later_mode", 128'(mb), 128'd0);
        checkOutput("pf_idle_bus", 128'({pnBus.pnMode, pnBus.pnOperator, pnBus.pnIn}), 128'd0);
        pnBus.pnOutValid = 1'b1;
        pnBus.pnOut      = 32'sd7;
        tick();
        pnBus.pnOutValid = 1'b0;
        pnBus.pnOut      = 32'sd0;
        tick();
        checkOutput("pf_done", 128'(done), 128'd1);
        checkOutput("pf_res_cnt", 128'(resCnt), 128'd1);
        checkOutput("pf_res_data", resData, 128'd7);
        checkOutput("pf_err", 128'(err), 128'd0);
        tick();
        checkOutput("pf_done_once", 128'(done), 128'd0);
        tick();
        checkOutput("pf_gap_busy", 128'(busy), 128'd1);
        tick();
        checkOutput("pf_idle_busy", 128'(busy), 128'd0);
        checkOutput("pf_done_count", 128'(doneCnt - d0), 128'd1);
    endtask

    initial begin
        int n, mb, k, v0, d0;
        logic [47:0] seen;
        logic [1:0]  fm;

        rst_n            = 1'b0;
        start            = 1'b0;
        cfgMode          = 2'd0;
        cfgLen           = 4'd0;
        cfgTokens        = 48'd0;
        pnBus.pnOutValid = 1'b0;
        pnBus.pnOut      = 32'sd0;
        repeat (3) tick();
        checkOutput("rst_outputs", 128'({busy, done, err, resCnt, pnBus.pnInValid,
                                         pnBus.pnMode, pnBus.pnOperator, pnBus.pnIn}), 128'd0);
        checkOutput("rst_data", resData, 128'd0);
        rst_n = 1'b1;
        tick();

        // Postfix-stack "3 4 +" answered with 7.
        runPostfixAdd();

        // Prefix-groups "* 3 5 - 2 6" answered with 15, -4.
        applyStimulus(2'd0, 4'd6, 48'h62953A);
        runSend(n, seen, fm, mb);
        checkOutput("grp_valid_cycles", 128'(n), 128'd6);
        checkOutput("grp_tokens", 128'(seen), 128'h62953A);
        checkOutput("grp_later_mode", 128'(mb), 128'd0);
        pnBus.pnOutValid = 1'b1;
        pnBus.pnOut      = 32'sd15;
        tick();
        pnBus.pnOut      = -32'sd4;
        tick();
        pnBus.pnOutValid = 1'b0;
        pnBus.pnOut      = 32'sd0;
        tick();
        checkOutput("grp_done", 128'(done), 128'd1);
        checkOutput("grp_res_cnt", 128'(resCnt), 128'd2);
        checkOutput("grp_res_data", resData, {64'd0, 32'hFFFF_FFFC, 32'd15});
        checkOutput("grp_err", 128'(err), 128'd0);
        tick();
        tick();
        checkOutput("grp_gap_busy", 128'(busy), 128'd1);
        tick();
        checkOutput("grp_idle_busy", 128'(busy), 128'd0);

        // Postfix-groups with length 5 is rejected without any token traffic.
        v0 = validCnt;
        applyStimulus(2'd1, 4'd5, 48'h12345);
        checkOutput("bad_no_early_done", 128'(done), 128'd0);
        tick();
        checkOutput("bad_done", 128'(done), 128'd1);
        checkOutput("bad_err", 128'(err), 128'd1);
        checkOutput("bad_res_cnt", 128'(resCnt), 128'd0);
        checkOutput("bad_res_cleared", resData, 128'd0);
        repeat (3) tick();
        checkOutput("bad_idle_busy", 128'(busy), 128'd0);
        checkOutput("bad_no_tokens", 128'(validCnt - v0), 128'd0);

        // Prefix-stack with no responder times out; a start during WAIT is ignored.
        applyStimulus(2'd2, 4'd3, 48'h218);
        runSend(n, seen, fm, mb);
        checkOutput("to_valid_cycles", 128'(n), 128'd3);
        checkOutput("to_first_mode", 128'(fm), 128'd2);
        cfgMode   = 2'd3;
        cfgLen    = 4'd3;
        cfgTokens = 48'h843;
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            start = (k == 3);
            tick();
            k++;
        end
        start = 1'b0;
        checkOutput("to_done_delay", 128'(k), 128'd17);
        checkOutput("to_err", 128'(err), 128'd2);
        checkOutput("to_res_cnt", 128'(resCnt), 128'd0);
        repeat (3) tick();
        checkOutput("to_idle_busy", 128'(busy), 128'd0);
        checkOutput("to_ignored_start", 128'(busy), 128'd0);

        // Prefix-stack answered twice: the extra result is an overrun.
        applyStimulus(2'd2, 4'd3, 48'h218);
        runSend(n, seen, fm, mb);
        pnBus.pnOutValid = 1'b1;
        pnBus.pnOut      = 32'sd9;
        tick();
        tick();
        pnBus.pnOutValid = 1'b0;
        pnBus.pnOut      = 32'sd0;
        tick();
        checkOutput("ovr_done", 128'(done), 128'd1);
        checkOutput("ovr_res_cnt", 128'(resCnt), 128'd1);
        checkOutput("ovr_res_data", resData, 128'd9);
        checkOutput("ovr_err", 128'(err), 128'd3);
        repeat (3) tick();

        // Prefix-groups expecting two results but receiving one.
        applyStimulus(2'd0, 4'd6, 48'h62953A);
        runSend(n, seen, fm, mb);
        pnBus.pnOutValid = 1'b1;
        pnBus.pnOut      = 32'sd5;
        tick();
        pnBus.pnOutValid = 1'b0;
        pnBus.pnOut      = 32'sd0;
        tick();
        checkOutput("short_done", 128'(done), 128'd1);
        checkOutput("short_res_cnt", 128'(resCnt), 128'd1);
        checkOutput("short_err", 128'(err), 128'd3);
        repeat (3) tick();
        checkOutput("short_retained_err", 128'(err), 128'd3);

        // Asynchronous reset in the middle of the token burst.
        d0 = doneCnt;
        applyStimulus(2'd3, 4'd3, 48'h843);
        tick();
        checkOutput("arst_tok0_valid", 128'(pnBus.pnInValid), 128'd1);
        tick();
        checkOutput("arst_tok1_in", 128'({pnBus.pnInValid, pnBus.pnIn}), 128'({1'b1, 3'd4}));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid_drop", 128'(pnBus.pnInValid), 128'd0);
        checkOutput("arst_outputs", 128'({busy, done, err, resCnt, pnBus.pnMode,
                                          pnBus.pnOperator, pnBus.pnIn}), 128'd0);
        checkOutput("arst_data", resData, 128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("arst_no_done", 128'(doneCnt - d0), 128'd0);
        runPostfixAdd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
